regfile_fwd: RTL and testbench

Parametrised general-purpose register file for the core's decode/register-read stage, succeeding the single-write-port register file. It provides NUM_RD registered read ports, two write ports (ALU writeback A, load writeback B) with same-cycle write-to-read forwarding, and a PC shadow register. It also keeps a pending-load scoreboard that flags read hazards to the issue logic.

---
 rtl/regfile_fwd_if.sv | 35 +++
 rtl/regfile_fwd.sv | 77 +++++++
 tb/tb_regfile_fwd.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_fwd_if.sv
// regfile_fwd_if: register-file bus bundle between decode/issue logic (master) and regfile_fwd (slave)
// Ports: i_stall, i_raddr (NUM_RD packed read addresses), i_pc, write port A (i_wa_*), write port B (i_wb_*),
//        i_pend_set_* (load-target marking); outputs o_rdata, o_hazard, o_pc_r, o_pend
interface regfile_fwd_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 3
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    logic                       i_stall;
    logic [NUM_RD*ADDR_W-1:0]   i_raddr;
    logic [NUM_RD*DATA_W-1:0]   o_rdata;
    logic [NUM_RD-1:0]          o_hazard;
    logic [DATA_W-1:0]          i_pc;
    logic [DATA_W-1:0]          o_pc_r;
    logic                       i_wa_en;
    logic [ADDR_W-1:0]          i_wa_addr;
    logic [DATA_W-1:0]          i_wa_data;
    logic                       i_wb_en;
    logic [ADDR_W-1:0]          i_wb_addr;
    logic [DATA_W-1:0]          i_wb_data;
    logic                       i_pend_set_en;
    logic [ADDR_W-1:0]          i_pend_set_addr;
    logic [NUM_REGS-1:0]        o_pend;
    modport master (
        output i_stall, i_raddr, i_pc, i_wa_en, i_wa_addr, i_wa_data,
               i_wb_en, i_wb_addr, i_wb_data, i_pend_set_en, i_pend_set_addr,
        input  o_rdata, o_hazard, o_pc_r, o_pend
    );
    modport slave (
        input  i_stall, i_raddr, i_pc, i_wa_en, i_wa_addr, i_wa_data,
               i_wb_en, i_wb_addr, i_wb_data, i_pend_set_en, i_pend_set_addr,
        output o_rdata, o_hazard, o_pc_r, o_pend
    );
endinterface

// File: rtl/regfile_fwd.sv
// regfile_fwd: dual-write register file with registered forwarding reads, PC shadow and pending-load scoreboard
// Ports: clk, rst (sync, active-low), io_bus (regfile_fwd_if.slave: read ports, write ports A/B,
//        PC in/out, scoreboard set and vector, per-port hazard flags)
module regfile_fwd #(
    parameter int                DATA_W   = 32,
    parameter int                NUM_REGS = 16,
    parameter int                NUM_RD   = 3,
    parameter int                PC_IDX   = 15,
    parameter int                SP_IDX   = 13,
    parameter logic [DATA_W-1:0] SP_RESET = '0
) (
    input logic          clk,
    input logic          rst,
    regfile_fwd_if.slave io_bus
);
    localparam int                ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0]   NREG   = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] PC_A   = ADDR_W'(PC_IDX);
    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]      r_pend;
    logic [NUM_RD*DATA_W-1:0] r_rdata;
    logic [NUM_RD-1:0]        r_hazard;
    logic [NUM_REGS-1:0]      w_wa_hit, w_wb_hit, w_set;
    logic [ADDR_W-1:0]        w_ra [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] w_rdata;
    logic [NUM_RD-1:0]        w_hazard;
    // One-hot write/set decode; addresses past NUM_REGS match nothing, so they are ignored
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wa_hit[i] = io_bus.i_wa_en && io_bus.i_wa_addr == ADDR_W'(i);
            w_wb_hit[i] = io_bus.i_wb_en && io_bus.i_wb_addr == ADDR_W'(i);
            w_set[i]    = io_bus.i_pend_set_en && io_bus.i_pend_set_addr == ADDR_W'(i) && i != PC_IDX;
        end
    end
    always_comb begin
        w_rdata  = '0;
        w_hazard = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            w_ra[k] = io_bus.i_raddr[k*ADDR_W +: ADDR_W];
            if ({1'b0, w_ra[k]} < NREG) begin
                w_rdata[k*DATA_W +: DATA_W] = w_ra[k] == PC_A ? io_bus.i_pc :
                                              w_wa_hit[w_ra[k]] ? io_bus.i_wa_data :
                                              w_wb_hit[w_ra[k]] ? io_bus.i_wb_data : r_regs[w_ra[k]];
                // A load landing this cycle resolves the hazard it would otherwise raise
                w_hazard[k] = w_ra[k] != PC_A && r_pend[w_ra[k]] && !w_wb_hit[w_ra[k]];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            r_pend   <= '0;
            r_rdata  <= '0;
            r_hazard <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wa_hit[i])
                    r_regs[i] <= io_bus.i_wa_data;
                else if (w_wb_hit[i])
                    r_regs[i] <= io_bus.i_wb_data;
                else if (i == PC_IDX)
                    r_regs[i] <= io_bus.i_pc;
            end
            // Set beats clear: a new load to the same register keeps it pending
            r_pend <= w_set | (r_pend & ~w_wb_hit);
            if (!io_bus.i_stall) begin
                r_rdata  <= w_rdata;
                r_hazard <= w_hazard;
            end
        end
    end
    assign io_bus.o_rdata  = r_rdata;
    assign io_bus.o_hazard = r_hazard;
    assign io_bus.o_pend   = r_pend;
    assign io_bus.o_pc_r   = r_regs[PC_IDX];
endmodule

// File: tb/tb_regfile_fwd.sv
// tb_regfile_fwd: scoreboard bench for regfile_fwd against a behavioural register-file model
module tb_regfile_fwd;
    typedef struct packed {
        logic [95:0] rd;
        logic [2:0]  hz;
        logic [15:0] pd;
        logic [31:0] pc;
    } exp_t;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    logic [31:0] m_regs [16];
    logic [15:0] m_pend;
    logic [95:0] m_rd;
    logic [2:0]  m_hz;
    regfile_fwd_if #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(3)) bus ();
    regfile_fwd #(
        .DATA_W(32), .NUM_REGS(16), .NUM_RD(3), .PC_IDX(15), .SP_IDX(13), .SP_RESET(32'h8000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io_bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // Reference model: reads see pre-edge state plus forwarding; later assignments express write priority
    task automatic step();
        logic [3:0] a;
        if (!rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_regs[13] = 32'h8000;
            m_pend = '0;
            m_rd   = '0;
            m_hz   = '0;
        end else begin
            if (!bus.i_stall) begin
                for (int k = 0; k < 3; k++) begin
                    a = bus.i_raddr[k*4 +: 4];
                    if (a == 4'd15) m_rd[k*32 +: 32] = bus.i_pc;
                    else if (bus.i_wa_en && bus.i_wa_addr == a) m_rd[k*32 +: 32] = bus.i_wa_data;
                    else if (bus.i_wb_en && bus.i_wb_addr == a) m_rd[k*32 +: 32] = bus.i_wb_data;
                    else m_rd[k*32 +: 32] = m_regs[a];
                    m_hz[k] = a != 4'd15 && m_pend[a] && !(bus.i_wb_en && bus.i_wb_addr == a);
                end
            end
            if (bus.i_wb_en) m_pend[bus.i_wb_addr] = 1'b0;
            if (bus.i_pend_set_en && bus.i_pend_set_addr != 4'd15) m_pend[bus.i_pend_set_addr] = 1'b1;
            m_regs[15] = bus.i_pc;
            if (bus.i_wb_en) m_regs[bus.i_wb_addr] = bus.i_wb_data;
            if (bus.i_wa_en) m_regs[bus.i_wa_addr] = bus.i_wa_data;
        end
        q.push_back({m_rd, m_hz, m_pend, m_regs[15]});
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.i_stall = 1'b0;
        bus.i_raddr = '0;
        bus.i_wa_en = 1'b0;
        bus.i_wa_addr = '0;
        bus.i_wa_data = '0;
        bus.i_wb_en = 1'b0;
        bus.i_wb_addr = '0;
        bus.i_wb_data = '0;
        bus.i_pend_set_en = 1'b0;
        bus.i_pend_set_addr = '0;
    endtask
    task automatic wa(input logic [3:0] a, input logic [31:0] d);
        bus.i_wa_en = 1'b1;
        bus.i_wa_addr = a;
        bus.i_wa_data = d;
    endtask
    task automatic wb(input logic [3:0] a, input logic [31:0] d);
        bus.i_wb_en = 1'b1;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
    endtask
    task automatic pset(input logic [3:0] a);
        bus.i_pend_set_en = 1'b1;
        bus.i_pend_set_addr = a;
    endtask
    function automatic logic [3:0] raddr_rand();
        return ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
    endfunction
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("mon_rdata", bus.o_rdata, e.rd);
                chk("mon_hazard", 96'(bus.o_hazard), 96'(e.hz));
                chk("mon_pend", 96'(bus.o_pend), 96'(e.pd));
                chk("mon_pc_r", 96'(bus.o_pc_r), 96'(e.pc));
            end
        end
    end
    initial begin
        rst = 1'b0;
        idle();
        bus.i_pc = 32'h100;
        step();
        step();
        chk("rst_pc_r", 96'(bus.o_pc_r), 96'h0);
        chk("rst_rdata", bus.o_rdata, 96'h0);
        rst = 1'b1;
        idle();
        bus.i_raddr = {4'd0, 4'd0, 4'd13};
        step();
        chk("sp_reset", 96'(bus.o_rdata[31:0]), 96'h8000);
        chk("pc_shadow", 96'(bus.o_pc_r), 96'h100);
        idle();
        wa(4'd5, 32'h55);
        step();
        idle();
        wa(4'd3, 32'hAAAA);
        wb(4'd4, 32'hBBBB);
        bus.i_raddr = {4'd5, 4'd4, 4'd3};
        step();
        chk("fwd_abr", bus.o_rdata, {32'h55, 32'hBBBB, 32'hAAAA});
        idle();
        wa(4'd2, 32'h1);
        wb(4'd2, 32'h2);
        bus.i_raddr = {4'd0, 4'd0, 4'd2};
        step();
        chk("conflict_fwd", 96'(bus.o_rdata[31:0]), 96'h1);
        idle();
        bus.i_raddr = {4'd0, 4'd0, 4'd2};
        step();
        chk("conflict_array", 96'(bus.o_rdata[31:0]), 96'h1);
        idle();
        wa(4'd1, 32'h11);
        step();
        idle();
        bus.i_raddr = {4'd0, 4'd0, 4'd1};
        step();
        chk("pre_stall", 96'(bus.o_rdata[31:0]), 96'h11);
        idle();
        bus.i_stall = 1'b1;
        bus.i_raddr = {4'd0, 4'd0, 4'd1};
        wa(4'd1, 32'h22);
        bus.i_pc = 32'h104;
        step();
        chk("stall_hold", 96'(bus.o_rdata[31:0]), 96'h11);
        chk("stall_pc", 96'(bus.o_pc_r), 96'h104);
        idle();
        bus.i_raddr = {4'd0, 4'd0, 4'd1};
        step();
        chk("post_stall", 96'(bus.o_rdata[31:0]), 96'h22);
        idle();
        pset(4'd6);
        step();
        idle();
        bus.i_raddr = {4'd0, 4'd0, 4'd6};
        step();
        chk("haz_set", 96'(bus.o_hazard[0]), 96'h1);
        chk("pend6_set", 96'(bus.o_pend[6]), 96'h1);
        idle();
        bus.i_raddr = {4'd0, 4'd0, 4'd6};
        wb(4'd6, 32'h66);
        step();
        chk("haz_clr_fwd", 96'(bus.o_hazard[0]), 96'h0);
        chk("load_fwd", 96'(bus.o_rdata[31:0]), 96'h66);
        chk("pend6_clr", 96'(bus.o_pend[6]), 96'h0);
        idle();
        pset(4'd7);
        wb(4'd7, 32'h77);
        step();
        chk("set_wins", 96'(bus.o_pend[7]), 96'h1);
        idle();
        pset(4'd15);
        bus.i_pc = 32'h200;
        bus.i_raddr = {4'd0, 4'd0, 4'd15};
        step();
        chk("read_pc", 96'(bus.o_rdata[31:0]), 96'h200);
        chk("pend_pc_never", 96'(bus.o_pend[15]), 96'h0);
        idle();
        bus.i_pc = 32'h204;
        wa(4'd15, 32'h300);
        step();
        chk("pc_write_wins", 96'(bus.o_pc_r), 96'h300);
        rst = 1'b0;
        idle();
        wa(4'd4, 32'hDEAD);
        pset(4'd3);
        bus.i_raddr = {4'd7, 4'd4, 4'd13};
        step();
        chk("midrst_rdata", bus.o_rdata, 96'h0);
        chk("midrst_pend", 96'(bus.o_pend), 96'h0);
        chk("midrst_hazard", 96'(bus.o_hazard), 96'h0);
        chk("midrst_pc_r", 96'(bus.o_pc_r), 96'h0);
        rst = 1'b1;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 49) != 0);
            bus.i_stall = ($urandom_range(0, 4) == 0);
            bus.i_raddr = {raddr_rand(), raddr_rand(), raddr_rand()};
            bus.i_pc = $urandom;
            bus.i_wa_en = 1'($urandom_range(0, 1));
            bus.i_wa_addr = raddr_rand();
            bus.i_wa_data = $urandom;
            bus.i_wb_en = ($urandom_range(0, 2) == 0);
            bus.i_wb_addr = raddr_rand();
            bus.i_wb_data = $urandom;
            bus.i_pend_set_en = ($urandom_range(0, 2) == 0);
            bus.i_pend_set_addr = raddr_rand();
            step();
        end
        rst = 1'b1;
        idle();
        step();
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 96'(q.size()), 96'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
